// File: rtl/sensor_frame_stats.sv
`default_nettype none
// ============================================================================
// Module   : sensor_frame_stats
// Purpose  : Per-frame image statistics over a rectangular region of interest
//            (pixel sum, pixel count, saturated-pixel count, min, max), plus an
//            exposure-length timer and a completed-frame counter.
// Ports    : px_clk / px_reset        clock, synchronous active-high reset
//            exp_in                   exposure strobe
//            din / en_in / vs_in      D-lane pixel beat, beat valid, frame active
//            roi_x0..roi_y1, sat_thr  ROI bounds and threshold, taken at frame start
//            exp_time_out             last completed exposure length (cycles)
//            gray_sum_out .. max_out  statistics of the last completed frame
//            frame_cnt_out            completed frames (wrapping)
//            stats_valid              one-cycle pulse when frame outputs update
// Revision : 1.0 - initial release
// ============================================================================
module sensor_frame_stats #(
   parameter int D     = 4,
   parameter int PIX_W = 12,
   parameter int SUM_W = 48
) (
   input  logic               px_clk,
   input  logic               px_reset,
   input  logic               exp_in,
   input  logic [PIX_W*D-1:0] din,
   input  logic               en_in,
   input  logic               vs_in,
   input  logic [15:0]        roi_x0,
   input  logic [15:0]        roi_x1,
   input  logic [15:0]        roi_y0,
   input  logic [15:0]        roi_y1,
   input  logic [PIX_W-1:0]   sat_thr,
   output logic [31:0]        exp_time_out,
   output logic [SUM_W-1:0]   gray_sum_out,
   output logic [31:0]        pix_cnt_out,
   output logic [31:0]        sat_cnt_out,
   output logic [PIX_W-1:0]   min_out,
   output logic [PIX_W-1:0]   max_out,
   output logic [15:0]        frame_cnt_out,
   output logic               stats_valid
);
   localparam int CW  = $clog2(D + 1);   // per-beat lane count width
   localparam int SW1 = PIX_W + CW;      // per-beat lane sum width
   localparam int AW  = SUM_W + 1;       // accumulator sum with carry

   // edge-detect and frame tracking
   logic exp_r_q, vs_r_q, en_r_q, seen_low_q, frame_q, end1_q;
   logic [31:0] exp_cnt_q;
   logic [15:0] x0_q, x1_q, y0_q, y1_q;
   logic [PIX_W-1:0] thr_q;
   logic [31:0] base_q, row_q;

   // reduction stage
   logic s1_v_q;
   logic [SW1-1:0] s1_sum_q;
   logic [CW-1:0] s1_cnt_q, s1_sat_q;
   logic [PIX_W-1:0] s1_min_q, s1_max_q;

   // accumulators
   logic [SUM_W-1:0] acc_sum_q, acc_sum_d;
   logic [31:0] acc_pix_q, acc_pix_d, acc_sat_q, acc_sat_d;
   logic [PIX_W-1:0] acc_min_q, acc_min_d, acc_max_q, acc_max_d;

   logic w_rise, w_end, w_en_fall, w_beat, w_row_ok;
   logic [31:0] w_base, w_row, w_col;
   logic [15:0] w_x0, w_x1, w_y0, w_y1;
   logic [PIX_W-1:0] w_thr, w_pix, w_min, w_max;
   logic [SW1-1:0] w_sum;
   logic [CW-1:0] w_cnt, w_sat;
   logic [AW-1:0] w_acc_sum;
   logic [32:0] w_acc_pix, w_acc_sat;

   // A rising edge only opens a frame once vs_in has been seen low since
   // reset, so a frame already in progress at reset release is ignored.
   assign w_rise    = vs_in & ~vs_r_q & seen_low_q;
   assign w_end     = ~vs_in & vs_r_q & frame_q;
   assign w_en_fall = ~en_in & en_r_q;
   assign w_beat    = en_in & vs_in & (frame_q | w_rise);

   // On the opening cycle the live ROI inputs apply; afterwards the sampled copy.
   assign w_x0  = w_rise ? roi_x0  : x0_q;
   assign w_x1  = w_rise ? roi_x1  : x1_q;
   assign w_y0  = w_rise ? roi_y0  : y0_q;
   assign w_y1  = w_rise ? roi_y1  : y1_q;
   assign w_thr = w_rise ? sat_thr : thr_q;
   assign w_base = w_rise ? 32'd0 : base_q;
   assign w_row  = w_rise ? 32'd0 : row_q;
   assign w_row_ok = (w_row >= {16'd0, w_y0}) && (w_row <= {16'd0, w_y1});

   // Lane reduction; an inverted ROI fails every comparison and so is empty.
   always_comb begin
      w_sum = '0;
      w_cnt = '0;
      w_sat = '0;
      w_min = '1;
      w_max = '0;
      w_pix = '0;
      w_col = '0;
      for (int i = 0; i < D; i++) begin
         w_pix = din[PIX_W*i +: PIX_W];
         w_col = w_base + 32'(i);
         if (w_beat && w_row_ok &&
             (w_col >= {16'd0, w_x0}) && (w_col <= {16'd0, w_x1})) begin
            w_sum = w_sum + SW1'(w_pix);
            w_cnt = w_cnt + CW'(1);
            if (w_pix >= w_thr) w_sat = w_sat + CW'(1);
            if (w_pix < w_min)  w_min = w_pix;
            if (w_pix > w_max)  w_max = w_pix;
         end
      end
   end

   always_ff @(posedge px_clk) begin
      if (px_reset) begin
         exp_r_q <= 1'b0; vs_r_q <= 1'b0; en_r_q <= 1'b0;
         seen_low_q <= 1'b0; frame_q <= 1'b0; end1_q <= 1'b0;
         exp_cnt_q <= '0; exp_time_out <= '0;
         x0_q <= '0; x1_q <= '0; y0_q <= '0; y1_q <= '0; thr_q <= '0;
         base_q <= '0; row_q <= '0;
         s1_v_q <= 1'b0; s1_sum_q <= '0; s1_cnt_q <= '0; s1_sat_q <= '0;
         s1_min_q <= '0; s1_max_q <= '0;
      end else begin
         exp_r_q <= exp_in;
         vs_r_q  <= vs_in;
         en_r_q  <= en_in;
         end1_q  <= w_end;
         if (!vs_in) seen_low_q <= 1'b1;

         if (exp_in) begin
            if (exp_cnt_q != '1) exp_cnt_q <= exp_cnt_q + 32'd1;
         end else begin
            exp_cnt_q <= '0;
         end
         if (!exp_in && exp_r_q) exp_time_out <= exp_cnt_q;

         if (w_rise) begin
            frame_q <= 1'b1;
            x0_q <= roi_x0; x1_q <= roi_x1;
            y0_q <= roi_y0; y1_q <= roi_y1;
            thr_q <= sat_thr;
         end else if (!vs_in) begin
            frame_q <= 1'b0;
         end

         // column base restarts at each row; rows advance on en_in falling
         if (w_en_fall)   base_q <= '0;
         else if (w_beat) base_q <= w_base + 32'(D);
         else if (w_rise) base_q <= '0;

         if (w_rise) row_q <= '0;
         else if (w_en_fall && vs_in && frame_q) row_q <= row_q + 32'd1;

         s1_v_q   <= w_beat;
         s1_sum_q <= w_sum;
         s1_cnt_q <= w_cnt;
         s1_sat_q <= w_sat;
         s1_min_q <= w_min;
         s1_max_q <= w_max;
      end
   end

   assign w_acc_sum = {1'b0, acc_sum_q} + AW'(s1_sum_q);
   assign w_acc_pix = {1'b0, acc_pix_q} + 33'(s1_cnt_q);
   assign w_acc_sat = {1'b0, acc_sat_q} + 33'(s1_sat_q);

   // end1_q marks T+1: the last beat has been absorbed, so the totals are
   // final. They are latched (visible at T+2) and cleared on the same edge.
   always_comb begin
      acc_sum_d = acc_sum_q;
      acc_pix_d = acc_pix_q;
      acc_sat_d = acc_sat_q;
      acc_min_d = acc_min_q;
      acc_max_d = acc_max_q;
      if (end1_q) begin
         acc_sum_d = '0;
         acc_pix_d = '0;
         acc_sat_d = '0;
         acc_min_d = '1;
         acc_max_d = '0;
      end else if (s1_v_q) begin
         acc_sum_d = w_acc_sum[SUM_W] ? '1 : w_acc_sum[SUM_W-1:0];
         acc_pix_d = w_acc_pix[32] ? '1 : w_acc_pix[31:0];
         acc_sat_d = w_acc_sat[32] ? '1 : w_acc_sat[31:0];
         if (s1_min_q < acc_min_q) acc_min_d = s1_min_q;
         if (s1_max_q > acc_max_q) acc_max_d = s1_max_q;
      end
   end

   always_ff @(posedge px_clk) begin
      if (px_reset) begin
         acc_sum_q <= '0; acc_pix_q <= '0; acc_sat_q <= '0;
         acc_min_q <= '1; acc_max_q <= '0;
         gray_sum_out <= '0; pix_cnt_out <= '0; sat_cnt_out <= '0;
         min_out <= '0; max_out <= '0; frame_cnt_out <= '0;
         stats_valid <= 1'b0;
      end else begin
         acc_sum_q <= acc_sum_d;
         acc_pix_q <= acc_pix_d;
         acc_sat_q <= acc_sat_d;
         acc_min_q <= acc_min_d;
         acc_max_q <= acc_max_d;
         stats_valid <= end1_q;
         if (end1_q) begin
            gray_sum_out  <= acc_sum_q;
            pix_cnt_out   <= acc_pix_q;
            sat_cnt_out   <= acc_sat_q;
            min_out       <= acc_min_q;
            max_out       <= acc_max_q;
            frame_cnt_out <= frame_cnt_out + 16'd1;
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_sensor_frame_stats.sv
`default_nettype none
// ============================================================================
// Module   : tb_sensor_frame_stats
// Purpose  : Directed self-checking bench for sensor_frame_stats (D=4, PIX_W=12)
// Revision : 1.0 - initial release
// ============================================================================
module tb_sensor_frame_stats;
   logic        px_clk, px_reset, exp_in, en_in, vs_in;
   logic [47:0] din;
   logic [15:0] roi_x0, roi_x1, roi_y0, roi_y1;
   logic [11:0] sat_thr;
   logic [31:0] exp_time_out, pix_cnt_out, sat_cnt_out;
   logic [47:0] gray_sum_out;
   logic [11:0] min_out, max_out;
   logic [15:0] frame_cnt_out;
   logic        stats_valid;

   int n_cmp = 0;
   int n_bad = 0;
   int sv_cnt = 0;
   int sv_snap;

   sensor_frame_stats #(.D(4), .PIX_W(12), .SUM_W(48)) dut (
      .px_clk(px_clk), .px_reset(px_reset), .exp_in(exp_in), .din(din),
      .en_in(en_in), .vs_in(vs_in), .roi_x0(roi_x0), .roi_x1(roi_x1),
      .roi_y0(roi_y0), .roi_y1(roi_y1), .sat_thr(sat_thr),
      .exp_time_out(exp_time_out), .gray_sum_out(gray_sum_out),
      .pix_cnt_out(pix_cnt_out), .sat_cnt_out(sat_cnt_out),
      .min_out(min_out), .max_out(max_out), .frame_cnt_out(frame_cnt_out),
      .stats_valid(stats_valid)
   );

   initial px_clk = 1'b0;
   always #5 px_clk = ~px_clk;

   always @(negedge px_clk) if (stats_valid) sv_cnt++;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge px_clk);
      #1;
   endtask

   task automatic beat(input logic [11:0] p0, p1, p2, p3);
      en_in = 1'b1;
      din   = {p3, p2, p1, p0};
      tick();
   endtask

   task automatic idle();
      en_in = 1'b0;
      tick();
   endtask

   task automatic start_frame(input logic [15:0] x0, x1, y0, y1, input logic [11:0] thr);
      roi_x0 = x0; roi_x1 = x1; roi_y0 = y0; roi_y1 = y1; sat_thr = thr;
      en_in = 1'b0;
      vs_in = 1'b1;
      tick();
   endtask

   // Drops vs_in at the start of cycle T; returns at the falling edge of T+2.
   task automatic end_frame(input string tag);
      en_in = 1'b0;
      vs_in = 1'b0;
      @(negedge px_clk); chk({tag, ".sv_T"},   stats_valid, 0);
      tick(); @(negedge px_clk); chk({tag, ".sv_T1"}, stats_valid, 0);
      tick(); @(negedge px_clk); chk({tag, ".sv_T2"}, stats_valid, 1);
   endtask

   task automatic check_stats(input string tag, input logic [47:0] sum,
                              input logic [31:0] pix, sat,
                              input logic [11:0] mn, mx, input logic [15:0] fc);
      chk({tag, ".sum"}, gray_sum_out, sum);
      chk({tag, ".pix"}, pix_cnt_out, pix);
      chk({tag, ".sat"}, sat_cnt_out, sat);
      chk({tag, ".min"}, min_out, mn);
      chk({tag, ".max"}, max_out, mx);
      chk({tag, ".fcnt"}, frame_cnt_out, fc);
   endtask

   initial begin
      px_reset = 1'b1; exp_in = 1'b0; en_in = 1'b0; vs_in = 1'b0; din = '0;
      roi_x0 = 0; roi_x1 = 16'hFFFF; roi_y0 = 0; roi_y1 = 16'hFFFF; sat_thr = 12'hFFF;
      repeat (3) tick();
      px_reset = 1'b0;
      tick();
      @(negedge px_clk);
      check_stats("rst", 0, 0, 0, 0, 0, 0);
      chk("rst.exp", exp_time_out, 0);
      chk("rst.sv", stats_valid, 0);
      tick();

      // exposure of 100 cycles
      exp_in = 1'b1;
      repeat (100) tick();
      chk("exp.during", exp_time_out, 0);
      exp_in = 1'b0;
      tick();
      chk("exp.len", exp_time_out, 100);
      repeat (3) tick();
      chk("exp.hold", exp_time_out, 100);

      // full ROI, 2 rows x 2 beats of 0x100
      sv_snap = sv_cnt;
      start_frame(16'h0, 16'hFFFF, 16'h0, 16'hFFFF, 12'hFFF);
      beat(12'h100, 12'h100, 12'h100, 12'h100);
      beat(12'h100, 12'h100, 12'h100, 12'h100);
      idle();
      beat(12'h100, 12'h100, 12'h100, 12'h100);
      beat(12'h100, 12'h100, 12'h100, 12'h100);
      end_frame("full");
      check_stats("full", 4096, 16, 0, 12'h100, 12'h100, 1);
      tick(); repeat (3) tick();
      chk("full.pulses", sv_cnt - sv_snap, 1);
      chk("full.hold", gray_sum_out, 4096);

      // ROI columns 1..2, row 0 only
      start_frame(16'd1, 16'd2, 16'd0, 16'd0, 12'hFFF);
      beat(12'd10, 12'd20, 12'd30, 12'd40);
      beat(12'd10, 12'd20, 12'd30, 12'd40);
      idle();
      beat(12'd10, 12'd20, 12'd30, 12'd40);
      end_frame("roi");
      check_stats("roi", 50, 2, 0, 12'd20, 12'd30, 2);
      repeat (3) tick();

      // saturation: one lane at 0xFFF over 8 beats
      start_frame(16'h0, 16'hFFFF, 16'h0, 16'hFFFF, 12'hFFF);
      repeat (8) beat(12'hFFF, 12'd5, 12'd5, 12'd5);
      end_frame("sat");
      check_stats("sat", 32880, 32, 8, 12'd5, 12'hFFF, 3);
      repeat (3) tick();

      // frame A, vs low exactly 3 cycles, frame B
      start_frame(16'h0, 16'hFFFF, 16'h0, 16'hFFFF, 12'hFFF);
      beat(12'd1, 12'd2, 12'd3, 12'd4);
      end_frame("A");
      check_stats("A", 10, 4, 0, 12'd1, 12'd4, 4);
      tick();
      chk("A.sv_T3", stats_valid, 0);
      start_frame(16'h0, 16'hFFFF, 16'h0, 16'hFFFF, 12'd300);
      beat(12'd100, 12'd200, 12'd300, 12'd400);

      // frame B ends; frame C rises at T+1 with a beat at T+2
      en_in = 1'b0; vs_in = 1'b0;
      tick();
      vs_in = 1'b1;
      tick();
      beat(12'd7, 12'd7, 12'd7, 12'd7);
      chk("B.sv_T3", stats_valid, 0);
      en_in = 1'b0;
      end_frame("C");
      check_stats("C", 28, 4, 0, 12'd7, 12'd7, 6);
      repeat (3) tick();

      // check B by repeating its pattern alone (latched value checked at T+2)
      start_frame(16'h0, 16'hFFFF, 16'h0, 16'hFFFF, 12'd300);
      beat(12'd100, 12'd200, 12'd300, 12'd400);
      end_frame("B");
      check_stats("B", 1000, 4, 2, 12'd100, 12'd400, 7);
      repeat (3) tick();

      // inverted ROI -> empty frame
      start_frame(16'd5, 16'd4, 16'h0, 16'hFFFF, 12'hFFF);
      beat(12'd9, 12'd9, 12'd9, 12'd9);
      end_frame("empty");
      check_stats("empty", 0, 0, 0, 12'hFFF, 12'd0, 8);
      repeat (3) tick();

      // reset mid-frame
      start_frame(16'h0, 16'hFFFF, 16'h0, 16'hFFFF, 12'hFFF);
      beat(12'd9, 12'd9, 12'd9, 12'd9);
      sv_snap = sv_cnt;
      px_reset = 1'b1;
      repeat (2) tick();
      px_reset = 1'b0;
      beat(12'd5, 12'd5, 12'd5, 12'd5);
      en_in = 1'b0; vs_in = 1'b0;
      repeat (5) tick();
      chk("mrst.pulses", sv_cnt - sv_snap, 0);
      check_stats("mrst", 0, 0, 0, 0, 0, 0);
      chk("mrst.exp", exp_time_out, 0);
      start_frame(16'h0, 16'hFFFF, 16'h0, 16'hFFFF, 12'hFFF);
      beat(12'd3, 12'd3, 12'd3, 12'd3);
      idle();
      beat(12'd3, 12'd3, 12'd3, 12'd3);
      end_frame("post");
      check_stats("post", 24, 8, 0, 12'd3, 12'd3, 1);
      repeat (2) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
